// File: rtl/tdm_pkg.sv
// Shared types and constants for the 8:1 TDM receive path.
package tdm_pkg;

    localparam int unsigned N_CH  = 8;
    localparam int unsigned SEL_W = $clog2(N_CH);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // One-hot decode of a slot index.
    function automatic logic [N_CH-1:0] slot_onehot(input logic [SEL_W-1:0] sel);
        slot_onehot      = '0;
        slot_onehot[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/tdm_demux8_rx_if.sv
// Serial slot input and assembled-frame output bundle of the TDM receiver.
interface tdm_demux8_rx_if;
    import tdm_pkg::*;

    logic             din;
    logic             din_vld;
    logic             fsync;
    logic [N_CH-1:0]  dout;
    logic             dout_vld;
    logic [SEL_W-1:0] slot;
    logic [N_CH-1:0]  ch_en;
    logic             sync_err;
    logic             locked;

    modport master (
        output din, din_vld, fsync,
        input  dout, dout_vld, slot, ch_en, sync_err, locked
    );

    modport slave (
        input  din, din_vld, fsync,
        output dout, dout_vld, slot, ch_en, sync_err, locked
    );

endinterface

// File: rtl/decoder_3_8_en.sv
// Slot index plus enable to one-hot channel write enable.
module decoder_3_8_en #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [N_CH-1:0]  onehot_c
);

    always_comb begin
        onehot_c = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            onehot_c[k] = en && (sel == SEL_W'(k));
        end
    end

endmodule

// File: rtl/tdm_demux8_rx.sv
// TDM receiver: routes serial slot bits into a shadow frame, publishes complete
// frames on dout and tracks frame alignment from fsync.
module tdm_demux8_rx
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    tdm_demux8_rx_if.slave   bus
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);
    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] slot_q, slot_d;
    logic [N_CH-1:0]  shadow_q, shadow_d;
    logic [N_CH-1:0]  dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             sync_err_q, sync_err_d;
    logic [N_CH-1:0]  ch_en_c;

    decoder_3_8_en #(.N_CH(N_CH), .SEL_W(SEL_W)) u_dec (
        .sel      (slot_q),
        .en       (bus.din_vld && (state_q == RUN)),
        .onehot_c (ch_en_c)
    );

    // Alignment state machine and shadow-frame write path.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        shadow_d   = shadow_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        sync_err_d = 1'b0;
        if (bus.din_vld) begin
            case (state_q)
                HUNT: begin
                    if (bus.fsync) begin
                        shadow_d[0] = bus.din;
                        slot_d      = SLOT_ONE;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (bus.fsync) begin
                        // A sync anywhere but slot 0 restarts the frame.
                        sync_err_d  = (slot_q != '0);
                        shadow_d[0] = bus.din;
                        slot_d      = SLOT_ONE;
                    end else if (slot_q == '0) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end else begin
                        shadow_d = (shadow_q & ~ch_en_c) | ({N_CH{bus.din}} & ch_en_c);
                        slot_d   = slot_q + SLOT_ONE;
                        if (slot_q == LAST_SLOT) begin
                            dout_d     = {bus.din, shadow_q[N_CH-2:0]};
                            dout_vld_d = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            slot_q     <= '0;
            shadow_q   <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            shadow_q   <= shadow_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.slot     = slot_q;
    assign bus.ch_en    = ch_en_c;
    assign bus.sync_err = sync_err_q;
    assign bus.locked   = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux8_rx.sv
// Scoreboard bench for tdm_demux8_rx: a behavioural model predicts every output
// each cycle and queues completed frames for comparison on dout_vld.
module tb_tdm_demux8_rx;
    import tdm_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tdm_demux8_rx_if bus ();

    tdm_demux8_rx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_pops   = 0;
    logic [7:0]  sb_q[$];

    bit          armed = 1'b0;
    bit          m_run;
    int          m_slot;
    logic [7:0]  m_shadow;
    logic [7:0]  m_dout;
    logic        m_vld;
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        logic [7:0] exp_d;
        check("dout_vld", 32'(bus.dout_vld), 32'(m_vld));
        check("sync_err", 32'(bus.sync_err), 32'(m_err));
        check("vld_err_excl", 32'(bus.dout_vld & bus.sync_err), 32'd0);
        check("locked", 32'(bus.locked), 32'(m_run));
        check("slot", 32'(bus.slot), 32'(m_slot));
        check("dout", 32'(bus.dout), 32'(m_dout));
        if (bus.dout_vld === 1'b1) begin
            check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_d = sb_q.pop_front();
                n_pops++;
                check("sb_dout", 32'(bus.dout), 32'(exp_d));
            end
        end
    endtask

    // One clock of stimulus: check last cycle's outputs, drive, check ch_en, advance model.
    task automatic cycle(input logic r, input logic b, input logic v, input logic fs);
        logic [N_CH-1:0] exp_en;
        @(negedge clk);
        if (armed) check_outputs();
        rst_n       = r;
        bus.din     = b;
        bus.din_vld = v;
        bus.fsync   = fs;
        #1;
        exp_en = (v && m_run) ? slot_onehot(SEL_W'(m_slot)) : '0;
        if (armed) check("ch_en", 32'(bus.ch_en), 32'(exp_en));
        m_vld = 1'b0;
        m_err = 1'b0;
        if (!r) begin
            m_run    = 1'b0;
            m_slot   = 0;
            m_shadow = 8'h00;
            m_dout   = 8'h00;
        end else if (v) begin
            if (!m_run) begin
                if (fs) begin
                    m_shadow[0] = b;
                    m_slot      = 1;
                    m_run       = 1'b1;
                end
            end else if (fs) begin
                m_err       = (m_slot != 0);
                m_shadow[0] = b;
                m_slot      = 1;
            end else if (m_slot == 0) begin
                m_err = 1'b1;
                m_run = 1'b0;
            end else begin
                m_shadow[m_slot] = b;
                if (m_slot == 7) begin
                    m_dout = m_shadow;
                    m_vld  = 1'b1;
                    sb_q.push_back(m_shadow);
                    m_slot = 0;
                end else begin
                    m_slot = m_slot + 1;
                end
            end
        end
        if (!r) armed = 1'b1;
    endtask

    task automatic do_reset(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Send nbits LSB-first; invalid gap cycles carry random din/fsync noise.
    task automatic send_bits(input logic [7:0] data, input int nbits, input bit sync, input int gap_max);
        for (int k = 0; k < nbits; k++) begin
            if (gap_max > 0)
                repeat ($urandom_range(gap_max, 0)) cycle(1'b1, 1'($urandom), 1'b0, 1'($urandom));
            cycle(1'b1, data[k], 1'b1, sync && (k == 0));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.din     = 1'b0;
        bus.din_vld = 1'b0;
        bus.fsync   = 1'b0;
        m_run       = 1'b0;
        m_slot      = 0;
        m_shadow    = 8'h00;
        m_dout      = 8'h00;
        m_vld       = 1'b0;
        m_err       = 1'b0;

        do_reset(2);
        send_bits(8'hA5, 8, 1'b1, 0);
        idle(2);

        send_bits(8'h3C, 8, 1'b1, 5);
        idle(3);

        do_reset(1);
        send_bits(8'h6E, 5, 1'b0, 0);
        send_bits(8'hFF, 8, 1'b1, 0);
        idle(2);

        send_bits(8'h0F, 4, 1'b1, 0);
        send_bits(8'h81, 8, 1'b1, 0);
        idle(2);

        send_bits(8'h5A, 8, 1'b1, 0);
        idle(1);
        send_bits(8'h01, 1, 1'b0, 0);
        idle(2);
        send_bits(8'h12, 8, 1'b1, 2);
        idle(2);

        send_bits(8'hFF, 4, 1'b1, 0);
        do_reset(2);
        send_bits(8'hC3, 8, 1'b1, 0);
        send_bits(8'h01, 8, 1'b1, 0);
        send_bits(8'h02, 8, 1'b1, 0);
        idle(3);

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        check("frames", 32'(n_pops), 32'd9);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
